// File: rtl/cim_layer_scheduler.sv
// cim_layer_scheduler: token-passing start/function/back-pressure sequencer for a chain of CIM layers.
// Optional per-layer RUN watchdog is built when CIM_SCHED_WATCHDOG_EN is defined.
module cim_layer_scheduler #(
    parameter int unsigned num_layers      = 7,
    parameter int unsigned func_cycles     = 4,
    parameter int unsigned timeout_cycles  = 1024,
    parameter int unsigned frame_cnt_width = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_frame_valid,
    output logic                       o_frame_ready,
    output logic [num_layers-1:0]      o_start,
    output logic [num_layers-1:0]      o_func_start,
    input  logic [num_layers-1:0]      i_busy,
    output logic [num_layers-1:0]      o_next_busy,
    input  logic                       i_sink_busy,
    output logic                       o_frame_done,
    output logic [frame_cnt_width-1:0] o_frames_done,
    output logic [num_layers-1:0]      o_error
);
    localparam int unsigned FCW  = (func_cycles > 1) ? $clog2(func_cycles) : 1;
    localparam int unsigned LAST = num_layers - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FUNC = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    if (num_layers < 2 || func_cycles < 1 || timeout_cycles < 1) begin : g_bad_cfg
        $error("cim_layer_scheduler: unsupported parameter set");
    end

    state_t                     r_state          [num_layers];
    state_t                     w_state_nxt      [num_layers];
    logic [FCW-1:0]             r_fcnt           [num_layers];
    logic [FCW-1:0]             w_fcnt_nxt       [num_layers];
    logic [num_layers-1:0]      r_start;
    logic [num_layers-1:0]      w_start_nxt;
    logic [num_layers-1:0]      r_func_start;
    logic [num_layers-1:0]      w_func_start_nxt;
    logic [frame_cnt_width-1:0] r_frames_done;
    logic [num_layers-2:0]      w_fwd;
    logic [num_layers-1:0]      w_enter;
    logic [num_layers-1:0]      w_leave;
    logic                       w_release;

`ifdef CIM_SCHED_WATCHDOG_EN
    localparam int unsigned WDW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    logic [WDW-1:0]             r_wd_cnt         [num_layers];
    logic [WDW-1:0]             w_wd_nxt         [num_layers];
    logic [num_layers-1:0]      r_error;
    logic [num_layers-1:0]      w_error_nxt;
`endif

    // Hand-off only into a downstream layer that is IDLE in registered state (no bypass).
    for (genvar k = 0; k < LAST; k++) begin : g_link
        assign w_fwd[k]       = (r_state[k] == ST_HOLD) && (r_state[k+1] == ST_IDLE);
        assign o_next_busy[k] = (r_state[k+1] != ST_IDLE);
    end
    assign o_next_busy[LAST] = i_sink_busy;

    assign w_release     = (r_state[LAST] == ST_HOLD) && !i_sink_busy;
    assign w_enter       = {w_fwd, i_frame_valid};
    assign w_leave       = {w_release, w_fwd};
    assign o_frame_ready = (r_state[0] == ST_IDLE);
    assign o_frame_done  = w_release;
    assign o_start       = r_start;
    assign o_func_start  = r_func_start;
    assign o_frames_done = r_frames_done;

    // Per-layer next state; r_start doubles as the RUN grace-cycle marker.
    always_comb begin
        for (int k = 0; k < int'(num_layers); k++) begin
            w_state_nxt[k]      = r_state[k];
            w_fcnt_nxt[k]       = r_fcnt[k];
            w_start_nxt[k]      = 1'b0;
            w_func_start_nxt[k] = 1'b0;
`ifdef CIM_SCHED_WATCHDOG_EN
            w_wd_nxt[k]         = r_wd_cnt[k];
            w_error_nxt[k]      = r_error[k];
`endif
            case (r_state[k])
                ST_IDLE: begin
                    if (w_enter[k]) begin
                        w_state_nxt[k] = ST_RUN;
                        w_start_nxt[k] = 1'b1;
`ifdef CIM_SCHED_WATCHDOG_EN
                        w_wd_nxt[k]    = '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (!r_start[k] && !i_busy[k]) begin
                        w_state_nxt[k]      = ST_FUNC;
                        w_fcnt_nxt[k]       = '0;
                        w_func_start_nxt[k] = 1'b1;
                    end
`ifdef CIM_SCHED_WATCHDOG_EN
                    else if (r_wd_cnt[k] == WDW'(timeout_cycles - 1)) begin
                        w_state_nxt[k] = ST_IDLE;
                        w_error_nxt[k] = 1'b1;
                    end else begin
                        w_wd_nxt[k] = r_wd_cnt[k] + WDW'(1);
                    end
`endif
                end
                ST_FUNC: begin
                    if (r_fcnt[k] == FCW'(func_cycles - 1)) begin
                        w_state_nxt[k] = ST_HOLD;
                    end else begin
                        w_fcnt_nxt[k] = r_fcnt[k] + FCW'(1);
                    end
                end
                ST_HOLD: begin
                    if (w_leave[k]) begin
                        w_state_nxt[k] = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[k] = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(num_layers); k++) begin
                r_state[k] <= ST_IDLE;
                r_fcnt[k]  <= '0;
            end
            r_start       <= '0;
            r_func_start  <= '0;
            r_frames_done <= '0;
        end else begin
            for (int k = 0; k < int'(num_layers); k++) begin
                r_state[k] <= w_state_nxt[k];
                r_fcnt[k]  <= w_fcnt_nxt[k];
            end
            r_start      <= w_start_nxt;
            r_func_start <= w_func_start_nxt;
            if (w_release) begin
                r_frames_done <= r_frames_done + frame_cnt_width'(1);
            end
        end
    end

`ifdef CIM_SCHED_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(num_layers); k++) begin
                r_wd_cnt[k] <= '0;
            end
            r_error <= '0;
        end else begin
            for (int k = 0; k < int'(num_layers); k++) begin
                r_wd_cnt[k] <= w_wd_nxt[k];
            end
            r_error <= w_error_nxt;
        end
    end

    assign o_error = r_error;
`else
    assign o_error = '0;
`endif

endmodule
